uart_tx_serializer: RTL
=======================

# uart_tx_serializer

UART transmit serializer for the iohub byte path to the PC. It accepts bytes from the transmitting FSM through `tx_byte`/`transmit` and shifts each one out on the serial line `tx` as a standard asynchronous frame (start, 8 data bits LSB first, optional parity, 1 or 2 stop bits). A one-deep holding register lets the FSM queue the next byte while the current frame is shifting. `is_transmitting` falls exactly once per frame, which is what the upstream high-byte/low-byte sequencer counts.

## Interface
- `CLK_DIV`, 434: clk_i cycles per bit; legal range is 2..65535 (434 gives 115200 baud at 50 MHz).
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

- `clk_i`  in  1  single clock; all logic on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `tx_byte`  in  8  byte to send; sampled only when a byte is accepted.
- `transmit`  in  1  one-cycle request; a byte is accepted when `transmit && ready`.
- `tx`  out  1  serial line; idle high.
- `is_transmitting`  out  1  high from the first start-bit cycle through the last stop-bit cycle.
- `ready`  out  1  high when the holding register is empty.

## Operation
- State machine: IDLE → START → DATA → PARITY (only if PARITY≠0) → STOP → IDLE.
- Each bit state lasts exactly CLK_DIV cycles, timed by the baud counter. The counter clears on entry to START and advances to the next bit when it reaches CLK_DIV-1.
- DATA shifts the shifter right and sends bit 0 first. A 3-bit index leaves DATA after index 7.
- Parity bit:
  - Odd: the parity bit is `~^data`.
  - Even: the parity bit is `^data`.
  - It is computed from the byte as loaded into the shifter.
- STOP sends `tx=1` for STOP_BITS×CLK_DIV cycles.
- IDLE always lasts at least one cycle with `tx=1` and `is_transmitting=0`.
- Accepting a byte, while IDLE with the holding register empty:
  - The byte loads straight into the shifter and the FSM goes to START on the next edge.
  - `ready` stays 1.
- Accepting a byte, while not IDLE:
  - The byte goes to the holding register and `ready` drops to 0 on the next edge.
- In IDLE with the holding register valid:
  - The held byte moves to the shifter, the holding register clears (`ready`=1 next cycle), and the FSM goes to START.
  - Back-to-back frames are therefore separated by exactly one idle cycle.
- `transmit` while `ready`=0 is ignored: the byte is dropped and there is no other side effect.
- In IDLE with the holding register valid, `ready`=0, so a simultaneous `transmit` is ignored.
- Reset:
  - `tx`=1, `is_transmitting`=0, `ready`=1, state IDLE, holding register cleared, baud counter 0.
  - Reset mid-frame aborts the frame; `tx` is high after the reset edge.

## Timing
- Latency: a byte accepted at edge N (FSM idle) gives `tx`=0 from edge N+1 onward.
- Frame length: (1 + 8 + (PARITY≠0) + STOP_BITS) × CLK_DIV cycles.
- `is_transmitting` rises at edge N+1 and falls on the edge ending the last stop bit.
- Back-to-back: next start bit at (previous `is_transmitting` fall) + 1 edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `iohub_pkg`:
  - FSM state encoding (`TX_IDLE`, `TX_START`, `TX_DATA`, `TX_PARITY`, `TX_STOP`).
  - Parity codes (`PAR_NONE`/`PAR_ODD`/`PAR_EVEN`).
  - Default `CLK_DIV`.
- Sub-module `uart_baud_gen`: counter with synchronous clear, enable and a one-cycle `bit_tick` at CLK_DIV-1. The receive side reuses it.

## Test plan
Benches use CLK_DIV=4.
- Reset: hold `rst_i` 3 cycles → `tx`=1, `is_transmitting`=0, `ready`=1 throughout and after.
- Single byte, PARITY=0, STOP_BITS=1: `transmit` with `tx_byte`=0xA5 →
  - `tx` = 0 (4 cycles), then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 (4 cycles).
  - `is_transmitting` high for exactly 40 cycles.
  - `ready` stays 1.
- Back-to-back: 0x12 at idle, then 0x34 at cycle 10 →
  - `ready`=0 from cycle 11 until the gap cycle.
  - Exactly one idle cycle between frames.
  - Two `is_transmitting` falling edges.
  - Second frame's data bits are 0,0,1,0,1,1,0,0.
- Parity and stop bits: 0x07 with PARITY=2 → parity bit 1; with PARITY=1 → 0. STOP_BITS=2 → stop high for 8 cycles; frame is 48 cycles.
- Overflow: 0x11 idle, then 0x22 and 0x33 while busy →
  - 0x33 is dropped.
  - Exactly two frames (0x11, 0x22) appear on `tx`.
- Reset mid-frame: assert `rst_i` during data bit 3 of a frame while 0x55 is held →
  - `tx`=1 after the reset edge.
  - `ready`=1.
  - No further frame, and 0x55 is never sent.

Source files
------------

// File: rtl/iohub_pkg.sv
// Shared definitions for the iohub UART path: FSM encoding, parity codes,
// default baud divisor and the parity helper used by TX and RX.
package iohub_pkg;

  localparam int DEFAULT_CLK_DIV = 434;

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLK_DIV-1 while enabled and pulses bit_tick
// on the last cycle of each bit. Shared by the transmit and receive sides.
module uart_baud_gen
  import iohub_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clear,
  input  logic i_en,
  output logic o_bit_tick
);

  localparam logic [15:0] LP_LAST = 16'(CLK_DIV - 1);

  logic [15:0] r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i || i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= (r_count == LP_LAST) ? '0 : r_count + 16'd1;
    end
  end

  assign o_bit_tick = i_en && (r_count == LP_LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits, with a one-deep holding register for the next byte.
module uart_tx_serializer
  import iohub_pkg::*;
#(
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_byte,
  input  logic       transmit,
  output logic       tx,
  output logic       is_transmitting,
  output logic       ready
);

  localparam logic [2:0] LP_STOP_LAST = 3'(STOP_BITS - 1);

  logic [2:0] r_state;
  logic [7:0] r_shift;
  logic [7:0] r_hold;
  logic       r_hold_valid;
  logic       r_parity;
  logic [2:0] r_idx;
  logic       r_tx;
  logic       r_busy;

  logic       w_accept;
  logic       w_start_new;
  logic [7:0] w_load_byte;
  logic       w_bit_tick;
  logic       w_tx_next;

  assign w_accept    = transmit && !r_hold_valid;
  assign w_start_new = (r_state == TX_IDLE) && (r_hold_valid || w_accept);
  assign w_load_byte = r_hold_valid ? r_hold : tx_byte;

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_clear    (w_start_new),
    .i_en       (r_state != TX_IDLE),
    .o_bit_tick (w_bit_tick)
  );

  // Line level is registered from the state, so it trails the FSM by one cycle.
  always_comb begin
    w_tx_next = 1'b1;
    case (r_state)
      TX_START:  w_tx_next = 1'b0;
      TX_DATA:   w_tx_next = r_shift[0];
      TX_PARITY: w_tx_next = r_parity;
      default:   w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= TX_IDLE;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_parity     <= 1'b0;
      r_idx        <= '0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_tx   <= w_tx_next;
      r_busy <= (r_state != TX_IDLE);

      if (w_accept && (r_state != TX_IDLE)) begin
        r_hold       <= tx_byte;
        r_hold_valid <= 1'b1;
      end

      case (r_state)
        TX_IDLE: begin
          if (w_start_new) begin
            r_shift      <= w_load_byte;
            r_parity     <= parity_bit(w_load_byte, PARITY);
            r_idx        <= '0;
            r_hold_valid <= 1'b0;
            r_state      <= TX_START;
          end
        end
        TX_START: begin
          if (w_bit_tick) r_state <= TX_DATA;
        end
        TX_DATA: begin
          if (w_bit_tick) begin
            r_shift <= r_shift >> 1;
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_idx   <= '0;
              r_state <= (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
            end
          end
        end
        TX_PARITY: begin
          if (w_bit_tick) r_state <= TX_STOP;
        end
        TX_STOP: begin
          if (w_bit_tick) begin
            if (r_idx == LP_STOP_LAST) begin
              r_idx   <= '0;
              r_state <= TX_IDLE;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign tx              = r_tx;
  assign is_transmitting = r_busy;
  assign ready           = ~r_hold_valid;

endmodule
